// File: rtl/wishbone_arbiter_2to1.sv
// Two-master to one-slave Wishbone round-robin arbiter. A grant is held for the
// whole bus cycle of the granted master; the slave port is muxed from the state register.
module wishbone_arbiter_2to1 #(
  parameter int addr_width   = 8,
  parameter int data_width   = 8,
  parameter int strobe_width = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [addr_width-1:0]   m0_adr,
  input  logic [data_width-1:0]   m0_datwr,
  output logic [data_width-1:0]   m0_datrd,
  input  logic                    m0_we,
  input  logic                    m0_stb,
  output logic                    m0_ack,
  input  logic                    m0_cyc,
  input  logic [strobe_width-1:0] m0_sel,
  input  logic [addr_width-1:0]   m1_adr,
  input  logic [data_width-1:0]   m1_datwr,
  output logic [data_width-1:0]   m1_datrd,
  input  logic                    m1_we,
  input  logic                    m1_stb,
  output logic                    m1_ack,
  input  logic                    m1_cyc,
  input  logic [strobe_width-1:0] m1_sel,
  output logic [addr_width-1:0]   s_adr,
  output logic [data_width-1:0]   s_datwr,
  input  logic [data_width-1:0]   s_datrd,
  output logic                    s_we,
  output logic                    s_stb,
  output logic                    s_cyc,
  input  logic                    s_ack,
  output logic [strobe_width-1:0] s_sel,
  output logic [1:0]              gnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state, state_next;
  // last = 0: m0 was granted most recently; last = 1: m1 was
  logic   last;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next == GRANT0) last <= 1'b0;
      else if (state_next == GRANT1) last <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_next = last ? GRANT0 : GRANT1;
        else if (m0_cyc)      state_next = GRANT0;
        else if (m1_cyc)      state_next = GRANT1;
      end
      GRANT0: begin
        if (!m0_cyc) state_next = m1_cyc ? GRANT1 : IDLE;
      end
      GRANT1: begin
        if (!m1_cyc) state_next = m0_cyc ? GRANT0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Slave port mux; an idle bus drives all-zero and swallows stray acks
  always_comb begin
    s_adr   = '0;
    s_datwr = '0;
    s_we    = 1'b0;
    s_stb   = 1'b0;
    s_cyc   = 1'b0;
    s_sel   = '0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    gnt     = 2'b00;
    case (state)
      GRANT0: begin
        s_adr   = m0_adr;
        s_datwr = m0_datwr;
        s_we    = m0_we;
        s_stb   = m0_stb;
        s_cyc   = m0_cyc;
        s_sel   = m0_sel;
        m0_ack  = s_ack;
        gnt     = 2'b01;
      end
      GRANT1: begin
        s_adr   = m1_adr;
        s_datwr = m1_datwr;
        s_we    = m1_we;
        s_stb   = m1_stb;
        s_cyc   = m1_cyc;
        s_sel   = m1_sel;
        m1_ack  = s_ack;
        gnt     = 2'b10;
      end
      default: ;
    endcase
  end

  assign m0_datrd = s_datrd;
  assign m1_datrd = s_datrd;

endmodule

// File: tb/tb_wishbone_arbiter_2to1.sv
// Self-checking bench for wishbone_arbiter_2to1: directed scenarios with a
// scoreboard of expected grants and read data.
module tb_wishbone_arbiter_2to1;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] m0_adr, m0_datwr, m0_datrd, m0_sel;
  logic [7:0] m1_adr, m1_datwr, m1_datrd, m1_sel;
  logic       m0_we, m0_stb, m0_ack, m0_cyc;
  logic       m1_we, m1_stb, m1_ack, m1_cyc;
  logic [7:0] s_adr, s_datwr, s_datrd, s_sel;
  logic       s_we, s_stb, s_cyc, s_ack;
  logic [1:0] gnt;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] gnt_q[$];
  logic [7:0] dat_q[$];

  wishbone_arbiter_2to1 #(.addr_width(8), .data_width(8), .strobe_width(8)) dut (
    .clock(clock), .reset(reset),
    .m0_adr(m0_adr), .m0_datwr(m0_datwr), .m0_datrd(m0_datrd), .m0_we(m0_we),
    .m0_stb(m0_stb), .m0_ack(m0_ack), .m0_cyc(m0_cyc), .m0_sel(m0_sel),
    .m1_adr(m1_adr), .m1_datwr(m1_datwr), .m1_datrd(m1_datrd), .m1_we(m1_we),
    .m1_stb(m1_stb), .m1_ack(m1_ack), .m1_cyc(m1_cyc), .m1_sel(m1_sel),
    .s_adr(s_adr), .s_datwr(s_datwr), .s_datrd(s_datrd), .s_we(s_we),
    .s_stb(s_stb), .s_cyc(s_cyc), .s_ack(s_ack), .s_sel(s_sel), .gnt(gnt)
  );

  always #5 clock = ~clock;

  // Advance one rising edge; inputs are then driven 1 time unit after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    m0_adr = 8'h00; m0_datwr = 8'h00; m0_sel = 8'h00; m0_we = 0; m0_stb = 0; m0_cyc = 0;
    m1_adr = 8'h00; m1_datwr = 8'h00; m1_sel = 8'h00; m1_we = 0; m1_stb = 0; m1_cyc = 0;
    s_datrd = 8'h00; s_ack = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if (gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt got %b want 00", gnt); end
    vectors++;
    if ({s_cyc, s_stb, s_we} !== 3'b000) begin
      miscompares++; $display("FAIL reset_sctl got %b want 000", {s_cyc, s_stb, s_we});
    end
    vectors++;
    if ({m0_ack, m1_ack} !== 2'b00) begin
      miscompares++; $display("FAIL reset_acks got %b want 00", {m0_ack, m1_ack});
    end
  endtask

  task automatic test_single_read();
    logic [7:0] exp;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 8'h10; m0_we = 0; m0_sel = 8'h01;
    gnt_q.push_back(2'b01);
    step();
    #1;
    vectors++;
    if (gnt !== gnt_q[0]) begin miscompares++; $display("FAIL read_gnt got %b want %b", gnt, gnt_q[0]); end
    void'(gnt_q.pop_front());
    vectors++;
    if (s_adr !== 8'h10 || s_cyc !== 1'b1) begin
      miscompares++; $display("FAIL read_route got adr=%h cyc=%b want adr=10 cyc=1", s_adr, s_cyc);
    end
    s_ack = 1; s_datrd = 8'hA5;
    dat_q.push_back(8'hA5);
    #1;
    exp = dat_q.pop_front();
    vectors++;
    if (m0_ack !== 1'b1 || m0_datrd !== exp || m1_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL read_ack got m0_ack=%b datrd=%h m1_ack=%b want 1 %h 0", m0_ack, m0_datrd, m1_ack, exp);
    end
    step();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    step();
  endtask

  task automatic test_handoff();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 8'h21;
    m1_cyc = 1; m1_stb = 1; m1_adr = 8'h42;
    step();
    #1;
    vectors++;
    if (gnt !== 2'b01 || s_adr !== 8'h21) begin
      miscompares++; $display("FAIL tie_first got gnt=%b adr=%h want 01 21", gnt, s_adr);
    end
    // m0 drops cyc in the same cycle the slave acks: ack still forwarded
    m0_cyc = 0; m0_stb = 0; s_ack = 1; s_datrd = 8'h77;
    #1;
    vectors++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      miscompares++; $display("FAIL drop_ack got m0_ack=%b m1_ack=%b want 1 0", m0_ack, m1_ack);
    end
    step();
    s_ack = 0;
    #1;
    vectors++;
    if (gnt !== 2'b10 || s_adr !== 8'h42 || s_cyc !== 1'b1) begin
      miscompares++; $display("FAIL handoff got gnt=%b adr=%h cyc=%b want 10 42 1", gnt, s_adr, s_cyc);
    end
    m1_cyc = 0; m1_stb = 0;
    step();
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 8'h01;
    m1_cyc = 1; m1_stb = 1; m1_adr = 8'h02;
    gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
    gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
    step();
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_g = gnt_q.pop_front();
      vectors++;
      if (gnt !== exp_g) begin miscompares++; $display("FAIL fair_gnt%0d got %b want %b", k, gnt, exp_g); end
      s_ack = 1; s_datrd = 8'h50 + 8'(k);
      dat_q.push_back(8'h50 + 8'(k));
      #1;
      exp_d = dat_q.pop_front();
      vectors++;
      if (exp_g == 2'b01) begin
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_datrd !== exp_d) begin
          miscompares++;
          $display("FAIL fair_ack%0d got acks=%b%b dat=%h want 10 %h", k, m0_ack, m1_ack, m0_datrd, exp_d);
        end
      end else begin
        if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || m1_datrd !== exp_d) begin
          miscompares++;
          $display("FAIL fair_ack%0d got acks=%b%b dat=%h want 01 %h", k, m0_ack, m1_ack, m1_datrd, exp_d);
        end
      end
      step();
      s_ack = 0;
      if (exp_g == 2'b01) m0_cyc = 0; else m1_cyc = 0;
      step();
      m0_cyc = 1; m1_cyc = 1;
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_write_no_preempt();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_datwr = 8'h3C; m1_sel = 8'h01; m1_adr = 8'h80;
    step();
    #1;
    vectors++;
    if (gnt !== 2'b10 || s_we !== 1'b1 || s_datwr !== 8'h3C || s_sel !== 8'h01) begin
      miscompares++;
      $display("FAIL write_route got gnt=%b we=%b dat=%h sel=%h want 10 1 3c 01", gnt, s_we, s_datwr, s_sel);
    end
    m0_cyc = 1; m0_stb = 1; m0_adr = 8'h11;
    step();
    step();
    s_ack = 1;
    #1;
    vectors++;
    if (gnt !== 2'b10 || s_adr !== 8'h80 || m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL no_preempt got gnt=%b adr=%h acks=%b%b want 10 80 01", gnt, s_adr, m0_ack, m1_ack);
    end
    step();
    s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    step();
    #1;
    vectors++;
    if (gnt !== 2'b01 || s_adr !== 8'h11 || s_we !== 1'b0) begin
      miscompares++; $display("FAIL after_write got gnt=%b adr=%h we=%b want 01 11 0", gnt, s_adr, s_we);
    end
    m0_cyc = 0; m0_stb = 0;
    step();
  endtask

  task automatic test_spurious_ack();
    do_reset();
    s_ack = 1; s_datrd = 8'hEE;
    #1;
    vectors++;
    if ({m0_ack, m1_ack} !== 2'b00 || s_cyc !== 1'b0 || s_adr !== 8'h00) begin
      miscompares++;
      $display("FAIL spurious got acks=%b%b cyc=%b adr=%h want 00 0 00", m0_ack, m1_ack, s_cyc, s_adr);
    end
    step();
    #1;
    vectors++;
    if (gnt !== 2'b00) begin miscompares++; $display("FAIL spurious_idle got gnt=%b want 00", gnt); end
    s_ack = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 8'h99;
    step();
    #1;
    vectors++;
    if (gnt !== 2'b10 || s_stb !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset got gnt=%b stb=%b want 10 1", gnt, s_stb);
    end
    reset = 1;
    step();
    #1;
    vectors++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset got gnt=%b cyc=%b want 00 0", gnt, s_cyc);
    end
    reset = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 8'h05;
    step();
    #1;
    vectors++;
    if (gnt !== 2'b01 || s_adr !== 8'h05) begin
      miscompares++; $display("FAIL post_reset_tie got gnt=%b adr=%h want 01 05", gnt, s_adr);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_handoff();
    test_fairness();
    test_write_no_preempt();
    test_spurious_ack();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter_2to1.md
Name: wishbone_arbiter_2to1

Overview:
- Round-robin arbiter that shares one Wishbone slave port between two Wishbone masters, e.g. copperv instruction fetch (m0) and load/store unit (m1) sharing the memory bus.
- Grant is registered and held for the whole bus cycle (master cyc high), so a granted master owns the slave until it drops cyc.
- All ports are flattened master/slave signal groups with the same fields as the team's wishbone interface.

Parameters:
- addr_width, 8, width of wb_adr on all ports
- data_width, 8, width of wb_datwr/wb_datrd on all ports
- strobe_width, 8, width of wb_sel on all ports

Ports:
- clock  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- m0_adr, m1_adr  input  addr_width  master address
- m0_datwr, m1_datwr  input  data_width  master write data
- m0_datrd, m1_datrd  output  data_width  master read data
- m0_we, m1_we  input  1  master write enable
- m0_stb, m1_stb  input  1  master strobe
- m0_ack, m1_ack  output  1  master acknowledge
- m0_cyc, m1_cyc  input  1  master cycle request
- m0_sel, m1_sel  input  strobe_width  master byte select
- s_adr  output  addr_width  slave address
- s_datwr  output  data_width  slave write data
- s_datrd  input  data_width  slave read data
- s_we, s_stb, s_cyc  output  1  slave controls
- s_ack  input  1  slave acknowledge
- s_sel  output  strobe_width  slave byte select
- gnt  output  2  one-hot current grant (00 = idle), for debug/verification

Behaviour:
- State: IDLE, GRANT0, GRANT1; register last (last master granted). Reset: state=IDLE, last=1 (m0 wins first tie), gnt=00.
- IDLE: only m0_cyc -> GRANT0; only m1_cyc -> GRANT1; both -> the master != last; neither -> stay.
- GRANTx: stay while mx_cyc=1. When mx_cyc=0: if other master's cyc=1, go directly to its grant (no idle cycle); else IDLE. last updates to x on every entry to GRANTx.
- Latency: request seen at edge N -> grant at edge N+1; slave sees the granted master's signals from the cycle after the request. No bus-request preemption.
- Routing (combinational from state): in GRANTx, s_adr/s_datwr/s_we/s_stb/s_cyc/s_sel = mx_* and mx_ack = s_ack. The non-granted master's ack is 0.
- IDLE: s_cyc=s_stb=s_we=0, s_adr=0, s_datwr=0, s_sel=0; both acks 0.
- m0_datrd = m1_datrd = s_datrd always (qualified by ack at the master).
- s_ack while IDLE is ignored and not forwarded.
- Granted master drops cyc in the same cycle the slave acks: ack is forwarded that cycle; handoff/IDLE on the next edge.
- Reset mid-cycle: next edge forces IDLE; s_cyc=0 the cycle after reset asserts; an outstanding transfer is abandoned.
- Fairness: with both masters continuously requesting and each dropping cyc after one transfer, grants alternate strictly 0,1,0,1.

Test Plan:
- Reset then m0_cyc=m0_stb=1, m0_adr=0x10, m0_we=0 -> gnt=01 next cycle, s_adr=0x10, s_cyc=1; s_ack with s_datrd=0xA5 -> m0_ack=1, m0_datrd=0xA5, m1_ack=0.
- m0 and m1 request on the same cycle right after reset -> GRANT0 first; m0 drops cyc -> GRANT1 on the next edge with no IDLE cycle; s_adr switches to m1_adr.
- Both request continuously for 4 transfers (each master drops cyc for one cycle after its ack) -> gnt sequence 01,10,01,10.
- m1 write (m1_we=1, m1_datwr=0x3C, m1_sel=0x01) while m0 idle -> s_we=1, s_datwr=0x3C, s_sel=0x01; m0 raising cyc mid-transfer does not preempt; gnt stays 10 until m1_cyc=0.
- Spurious s_ack=1 while IDLE -> m0_ack=m1_ack=0, state stays IDLE.
- Assert reset while GRANT1 with stb high -> gnt=00 and s_cyc=0 after the edge; the next tie grants m0 (last reset to 1).
